sprite_read_arbiter: RTL and testbench
======================================

Name: sprite_read_arbiter

Overview:
- Shares the single registered read port of the 2704-entry, 24-bit sprite RAM between two requesters.
- Requester V is the VGA pixel renderer. It has priority because of pixel timing.
- Requester G is game logic, used for sprite-pixel collision and colour lookups. A wait counter protects G from starvation.
- Sits between the renderer/game-logic blocks and the sprite RAM. The RAM write port is untouched.

Parameters:
- ADDR_W, 12, sprite RAM address width.
- DATA_W, 24, RGB pixel width.
- DEPTH, 2704, number of valid RAM entries (52x52 sprite).
- MAX_WAIT, 8, number of consecutive denied G cycles before G is forced to win.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- vid_req  in  1  V read request; held until granted.
- vid_addr  in  ADDR_W  V read address; stable while vid_req is high.
- vid_gnt  out  1  V request accepted this cycle (combinational).
- vid_valid  out  1  V read data valid (registered, one-cycle pulse).
- vid_data  out  DATA_W  V read data; holds the last value between pulses.
- gl_req  in  1  G read request; held until granted.
- gl_addr  in  ADDR_W  G read address; stable while gl_req is high.
- gl_gnt  out  1  G request accepted this cycle (combinational).
- gl_valid  out  1  G read data valid (registered, one-cycle pulse).
- gl_data  out  DATA_W  G read data; holds the last value between pulses.
- ram_read_address  out  ADDR_W  to the RAM read_address input.
- ram_data_Out  in  DATA_W  from the RAM data_Out, valid one cycle after the address is presented.

Behaviour:
- Reset (synchronous, active-high) clears:
  - vid_valid, gl_valid = 0.
  - vid_data, gl_data = 0.
  - wait counter = 0.
  - both in-flight tag stages = idle.
  - ram_read_address = 0.
  - While Reset is high, vid_gnt = gl_gnt = 0.
- Arbitration, evaluated each cycle (cycle N) and combinational from the request inputs plus registered state:
  - Only vid_req: grant V.
  - Only gl_req: grant G.
  - Both, wait counter < MAX_WAIT: grant V.
  - Both, wait counter == MAX_WAIT: grant G.
  - Neither: no grant; ram_read_address holds its previous value.
  - At most one grant per cycle; vid_gnt and gl_gnt are never both 1.
- Address path: in grant cycle N, ram_read_address = the granted address (combinational mux). The RAM samples it at the end of cycle N.
- Pipeline:
  - Stage-1 tag register records {owner, in_range} at the end of cycle N.
  - In cycle N+1, ram_data_Out is valid.
  - At the end of N+1, data is captured into the owner's data register and the owner's valid is set.
  - In cycle N+2, owner_valid = 1 for exactly one cycle and owner_data = the RAM word.
  - Fixed latency: grant to valid = 2 cycles.
  - Throughput: one grant per cycle. Back-to-back grants to either requester are legal and yield consecutive valid pulses.
- Out-of-range: granted address >= DEPTH is still granted and completes with normal latency. The RAM word is ignored and owner_data = 0.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle gl_req = 1 and gl_gnt = 0.
  - Clears on a G grant or when gl_req = 0.
- Request handshake:
  - A requester dropping req before its grant is legal; nothing is issued.
  - An address change while req = 1 and not granted is legal; the address sampled in the grant cycle wins.
- Reset mid-operation: in-flight reads are discarded. No valid pulse appears after Reset deasserts unless a new grant occurs.

Test Plan:
- Reset, then vid_req = 1 with vid_addr = 12'h000, RAM[0] = 24'hFFFF00 -> vid_gnt = 1 in cycle 0; vid_valid = 1 and vid_data = 24'hFFFF00 in cycle 2; gl_valid stays 0.
- vid_req held high continuously and gl_req = 1 from cycle 0 -> G is denied cycles 0..7 and gl_gnt = 1 in cycle 8 (vid_gnt = 0 that cycle); gl_valid = 1 in cycle 10; counter returns to 0.
- Alternating single-cycle grants V, G, V with addresses 5, 6, 7 -> valid pulses in cycles 2, 3, 4 on the correct ports, carrying RAM[5], RAM[6], RAM[7].
- gl_req with gl_addr = 2704 (DEPTH) -> gl_gnt = 1; gl_valid = 1 two cycles later with gl_data = 24'h000000.
- Grant issued in cycle 0, Reset asserted in cycle 1 -> no valid pulse in cycle 2; all outputs 0; no spurious valid after Reset deasserts.
- gl_req high 5 cycles, low 1 cycle, high again while vid_req is held -> counter restarts; G is granted only after 8 further denied cycles.

Source files
------------

// File: rtl/sprite_read_arbiter_if.sv
// Requester-side bundle for the sprite RAM read arbiter: the VGA renderer (vid_*)
// and game logic (gl_*) request/grant/response signals.
interface sprite_read_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 24
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;

    logic              gl_req;
    logic [ADDR_W-1:0] gl_addr;
    logic              gl_gnt;
    logic              gl_valid;
    logic [DATA_W-1:0] gl_data;

    // Requesters drive request and address; they receive grant and read data.
    modport master (
        output vid_req, vid_addr, gl_req, gl_addr,
        input  vid_gnt, vid_valid, vid_data, gl_gnt, gl_valid, gl_data
    );

    // The arbiter consumes requests and returns grant and read data.
    modport slave (
        input  vid_req, vid_addr, gl_req, gl_addr,
        output vid_gnt, vid_valid, vid_data, gl_gnt, gl_valid, gl_data
    );
endinterface

// File: rtl/sprite_read_arbiter.sv
// Shares the registered sprite RAM read port between the VGA renderer (priority)
// and game logic (starvation-protected by a wait counter); fixed 2-cycle latency.
module sprite_read_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned DEPTH    = 2704,
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic                  Clk,
    input  logic                  Reset,
    sprite_read_arbiter_if.slave  req_bus,
    output logic [ADDR_W-1:0]     ram_read_address,
    input  logic [DATA_W-1:0]     ram_data_Out
);
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_q;
    logic [ADDR_W-1:0] addr_q;
    logic              s1_valid_q;
    logic              s1_gl_q;
    logic              s1_in_range_q;
    logic              vid_valid_q;
    logic              gl_valid_q;
    logic [DATA_W-1:0] vid_data_q;
    logic [DATA_W-1:0] gl_data_q;

    logic              starved_c;
    logic              vid_gnt_c;
    logic              gl_gnt_c;
    logic              any_gnt_c;
    logic [ADDR_W-1:0] gnt_addr_c;
    logic              in_range_c;

    assign starved_c = (wait_q == WAIT_W'(MAX_WAIT));

    // Video wins by default; game logic wins when alone or once it has starved.
    always_comb begin
        vid_gnt_c = 1'b0;
        gl_gnt_c  = 1'b0;
        if (!Reset) begin
            if (req_bus.gl_req && (!req_bus.vid_req || starved_c)) begin
                gl_gnt_c = 1'b1;
            end else if (req_bus.vid_req) begin
                vid_gnt_c = 1'b1;
            end
        end
    end

    assign any_gnt_c  = vid_gnt_c | gl_gnt_c;
    assign gnt_addr_c = gl_gnt_c ? req_bus.gl_addr : req_bus.vid_addr;
    assign in_range_c = (32'(gnt_addr_c) < DEPTH);

    // Idle cycles replay the last issued address so the RAM input stays quiet.
    always_comb begin
        ram_read_address = addr_q;
        if (Reset) begin
            ram_read_address = '0;
        end else if (any_gnt_c) begin
            ram_read_address = gnt_addr_c;
        end
    end

    // Wait counter saturates at MAX_WAIT; any break in the G request restarts it.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_q <= '0;
        end else if (!req_bus.gl_req || gl_gnt_c) begin
            wait_q <= '0;
        end else if (!starved_c) begin
            wait_q <= wait_q + WAIT_W'(1);
        end
    end

    // Stage 1 tags the read in flight; stage 2 steers the RAM word to its owner.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q        <= '0;
            s1_valid_q    <= 1'b0;
            s1_gl_q       <= 1'b0;
            s1_in_range_q <= 1'b0;
            vid_valid_q   <= 1'b0;
            gl_valid_q    <= 1'b0;
            vid_data_q    <= '0;
            gl_data_q     <= '0;
        end else begin
            if (any_gnt_c) begin
                addr_q <= gnt_addr_c;
            end
            s1_valid_q    <= any_gnt_c;
            s1_gl_q       <= gl_gnt_c;
            s1_in_range_q <= in_range_c;
            vid_valid_q   <= s1_valid_q && !s1_gl_q;
            gl_valid_q    <= s1_valid_q && s1_gl_q;
            if (s1_valid_q && !s1_gl_q) begin
                vid_data_q <= s1_in_range_q ? ram_data_Out : '0;
            end
            if (s1_valid_q && s1_gl_q) begin
                gl_data_q <= s1_in_range_q ? ram_data_Out : '0;
            end
        end
    end

    assign req_bus.vid_gnt   = vid_gnt_c;
    assign req_bus.gl_gnt    = gl_gnt_c;
    assign req_bus.vid_valid = vid_valid_q;
    assign req_bus.gl_valid  = gl_valid_q;
    assign req_bus.vid_data  = vid_data_q;
    assign req_bus.gl_data   = gl_data_q;

    grant_onehot: assert property (@(posedge Clk) !(vid_gnt_c && gl_gnt_c));

endmodule

// File: tb/tb_sprite_read_arbiter.sv
// Randomized bench for sprite_read_arbiter: a queue-based model of the arbitration
// rules checked every cycle, plus directed cases with literal expectations.
module tb_sprite_read_arbiter;
    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 24;
    localparam int unsigned DEPTH    = 2704;
    localparam int unsigned MAX_WAIT = 8;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [ADDR_W-1:0] ram_read_address;
    logic [DATA_W-1:0] ram_data_Out;
    logic [DATA_W-1:0] mem [4096];

    int checks   = 0;
    int failures = 0;

    sprite_read_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sprite_read_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .req_bus          (bus),
        .ram_read_address (ram_read_address),
        .ram_data_Out     (ram_data_Out)
    );

    always #5 Clk = ~Clk;

    // Registered-read RAM; words beyond DEPTH hold junk the arbiter must mask.
    always @(posedge Clk) ram_data_Out <= mem[ram_read_address];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int               due;
        bit               gl;
        logic [DATA_W-1:0] data;
    } rd_t;

    rd_t               pipe[$];
    int                cyc = 0;
    bit                live = 1'b0;
    int                wait_m = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [DATA_W-1:0] hold_v = '0;
    logic [DATA_W-1:0] hold_g = '0;

    always @(negedge Clk) begin : cmp
        bit ev, eg, gv, gg;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] d;
        ev = 1'b0;
        eg = 1'b0;
        while (pipe.size() > 0 && pipe[0].due <= cyc) begin
            if (pipe[0].due == cyc) begin
                if (pipe[0].gl) begin eg = 1'b1; hold_g = pipe[0].data; end
                else            begin ev = 1'b1; hold_v = pipe[0].data; end
            end
            void'(pipe.pop_front());
        end
        gv = 1'b0;
        gg = 1'b0;
        if (!Reset) begin
            if (bus.gl_req && (!bus.vid_req || wait_m >= int'(MAX_WAIT))) gg = 1'b1;
            else if (bus.vid_req) gv = 1'b1;
        end
        ea = Reset ? '0 : gv ? bus.vid_addr : gg ? bus.gl_addr : last_addr;
        if (live) begin
            chk("m_vid_gnt",   32'(bus.vid_gnt),   32'(gv));
            chk("m_gl_gnt",    32'(bus.gl_gnt),    32'(gg));
            chk("m_ram_addr",  32'(ram_read_address), 32'(ea));
            chk("m_vid_valid", 32'(bus.vid_valid), 32'(ev));
            chk("m_gl_valid",  32'(bus.gl_valid),  32'(eg));
            chk("m_vid_data",  32'(bus.vid_data),  32'(hold_v));
            chk("m_gl_data",   32'(bus.gl_data),   32'(hold_g));
        end
        if (Reset) begin
            pipe.delete();
            wait_m    = 0;
            last_addr = '0;
            hold_v    = '0;
            hold_g    = '0;
            live      = 1'b1;
        end else begin
            if (gv || gg) begin
                d = (int'(ea) < int'(DEPTH)) ? mem[ea] : '0;
                pipe.push_back('{cyc + 2, gg, d});
                last_addr = ea;
            end
            if (!bus.gl_req || gg) wait_m = 0;
            else if (wait_m < int'(MAX_WAIT)) wait_m++;
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit vr, input logic [ADDR_W-1:0] va,
                         input bit gr, input logic [ADDR_W-1:0] ga);
        @(posedge Clk);
        #1;
        Reset        = r;
        bus.vid_req  = vr;
        bus.vid_addr = va;
        bus.gl_req   = gr;
        bus.gl_addr  = ga;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        int n;
        bit vr, gr, rs;
        logic [ADDR_W-1:0] va, ga;

        for (int i = 0; i < 4096; i++) mem[i] = DATA_W'($urandom);
        mem[0]    = 24'hFFFF00;
        mem[5]    = 24'h050505;
        mem[6]    = 24'h606060;
        mem[7]    = 24'h7A7A7A;
        mem[20]   = 24'h123456;
        mem[2704] = 24'hABCDEF;

        Reset = 1'b1;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.gl_req  = 1'b0; bus.gl_addr  = '0;
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);

        // Single video read of address 0.
        drive(1'b0, 1'b1, 12'h000, 1'b0, '0);
        @(negedge Clk);
        chk("rst_vid_valid", 32'(bus.vid_valid), 32'h0);
        chk("rst_vid_data",  32'(bus.vid_data),  32'h0);
        chk("v0_gnt",        32'(bus.vid_gnt),   32'h1);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("v0_valid",    32'(bus.vid_valid), 32'h1);
        chk("v0_data",     32'(bus.vid_data),  32'hFFFF00);
        chk("v0_gl_valid", 32'(bus.gl_valid),  32'h0);
        idle(2);

        // Starvation: video held, game logic granted on its 9th cycle.
        for (int k = 0; k < 9; k++) begin
            drive(1'b0, 1'b1, 12'd10, 1'b1, 12'd20);
            @(negedge Clk);
            if (k < 8) chk("starve_denied", 32'(bus.gl_gnt), 32'h0);
            else begin
                chk("starve_gl_gnt",  32'(bus.gl_gnt),  32'h1);
                chk("starve_vid_gnt", 32'(bus.vid_gnt), 32'h0);
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("starve_gl_valid", 32'(bus.gl_valid), 32'h1);
        chk("starve_gl_data",  32'(bus.gl_data),  32'h123456);
        idle(2);

        // Out-of-range game-logic read returns zero.
        drive(1'b0, 1'b0, '0, 1'b1, 12'd2704);
        @(negedge Clk);
        chk("oor_gnt", 32'(bus.gl_gnt), 32'h1);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("oor_valid", 32'(bus.gl_valid), 32'h1);
        chk("oor_data",  32'(bus.gl_data),  32'h0);
        idle(2);

        // Interleaved V5, G6, V7.
        drive(1'b0, 1'b1, 12'd5, 1'b0, '0);
        drive(1'b0, 1'b0, '0, 1'b1, 12'd6);
        drive(1'b0, 1'b1, 12'd7, 1'b0, '0);
        @(negedge Clk);
        chk("alt_v5_valid", 32'(bus.vid_valid), 32'h1);
        chk("alt_v5_data",  32'(bus.vid_data),  32'h050505);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("alt_g6_valid", 32'(bus.gl_valid),  32'h1);
        chk("alt_g6_vid",   32'(bus.vid_valid), 32'h0);
        chk("alt_g6_data",  32'(bus.gl_data),   32'h606060);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("alt_v7_valid", 32'(bus.vid_valid), 32'h1);
        chk("alt_v7_data",  32'(bus.vid_data),  32'h7A7A7A);
        idle(2);

        // Reset right after a grant discards the read.
        drive(1'b0, 1'b1, 12'd5, 1'b0, '0);
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("mid_rst_gnt", 32'(bus.vid_gnt), 32'h0);
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        @(negedge Clk);
        chk("mid_rst_vid_valid", 32'(bus.vid_valid), 32'h0);
        chk("mid_rst_gl_valid",  32'(bus.gl_valid),  32'h0);
        chk("mid_rst_vid_data",  32'(bus.vid_data),  32'h0);
        chk("mid_rst_gl_data",   32'(bus.gl_data),   32'h0);
        chk("mid_rst_addr",      32'(ram_read_address), 32'h0);
        idle(3);

        // A one-cycle gap in gl_req restarts the starvation count.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b1, 12'd30, 1'b1, 12'd40);
            @(negedge Clk);
            chk("gap_denied", 32'(bus.gl_gnt), 32'h0);
        end
        drive(1'b0, 1'b1, 12'd30, 1'b0, 12'd40);
        n = 20;
        for (int k = 0; k < 20; k++) begin
            drive(1'b0, 1'b1, 12'd30, 1'b1, 12'd40);
            @(negedge Clk);
            if (bus.gl_gnt) begin n = k; break; end
        end
        chk("gap_grant_cycle", 32'(n), 32'd8);
        idle(3);

        // Randomized traffic: balanced phase, then video-heavy phase.
        for (int i = 0; i < 4000; i++) begin
            rs = ($urandom_range(0, 299) == 0);
            if (i < 2000) begin
                vr = 1'($urandom_range(0, 1));
                gr = 1'($urandom_range(0, 1));
            end else begin
                vr = ($urandom_range(0, 19) != 0);
                gr = ($urandom_range(0, 9) != 0);
            end
            va = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095))
                                             : 12'($urandom_range(0, DEPTH - 1));
            ga = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095))
                                             : 12'($urandom_range(0, DEPTH - 1));
            drive(rs, vr, va, gr, ga);
        end
        idle(4);
        @(negedge Clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
